// File: rtl/cpu_cluster_mode_ctrl.sv
// Hart-set controller for the external CPU cluster: constant hart IDs, per-hart fetch
// enables, and a quiesce -> switch -> staggered-release sequence to change the active set.
module cpu_cluster_mode_ctrl #(
    parameter int unsigned        NHARTS         = 3,
    parameter logic [31:0]        HART_ID_BASE   = 32'h1,
    parameter logic [NHARTS-1:0]  RESET_MASK     = {NHARTS{1'b1}},
    parameter int unsigned        TIMEOUT_CYCLES = 255,
    parameter int unsigned        CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mode_req_valid_i,
    input  logic [NHARTS-1:0]      mode_req_mask_i,
    output logic                   mode_req_ready_o,
    input  logic [NHARTS-1:0]      sleep_i,
    input  logic [NHARTS-1:0]      ext_debug_req_i,
    output logic [NHARTS-1:0]      fetch_enable_o,
    output logic [NHARTS-1:0]      quiesce_irq_o,
    output logic [NHARTS-1:0][31:0] hart_id_o,
    output logic [NHARTS-1:0]      active_mask_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);

    localparam int unsigned       IDX_W    = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NHARTS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_SWITCH  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state_r,    state_s;
    logic [NHARTS-1:0] new_mask_r, new_mask_s;
    logic [NHARTS-1:0] active_r,   active_s;
    logic [NHARTS-1:0] fetch_r,    fetch_s;
    logic [NHARTS-1:0] qirq_r,     qirq_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_s;
    logic [IDX_W-1:0]  idx_r,      idx_s;
    logic              done_r,     done_s;
    logic              error_r,    error_s;
    logic              all_asleep_s;
    logic              freeze_s;

    // Constant, unique hart IDs.
    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart_id
        assign hart_id_o[gi] = HART_ID_BASE + 32'(gi);
    end

    assign all_asleep_s = ((sleep_i & active_r) == active_r);
    assign freeze_s     = |(ext_debug_req_i & active_r);

    // Next-state and next-output computation for the mode-switch sequence.
    always_comb begin
        state_s    = state_r;
        new_mask_s = new_mask_r;
        active_s   = active_r;
        fetch_s    = fetch_r;
        qirq_s     = qirq_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        done_s     = 1'b0;
        error_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mode_req_valid_i) begin
                    new_mask_s = mode_req_mask_i;
                    if (mode_req_mask_i == {NHARTS{1'b0}}) begin
                        error_s = 1'b1;
                    end else if (mode_req_mask_i == active_r) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_QUIESCE;
                        cnt_s   = {CNT_W{1'b0}};
                        qirq_s  = active_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_QUIESCE: begin
                // Success outranks a timeout landing in the same cycle.
                if (all_asleep_s) begin
                    state_s = ST_SWITCH;
                end else if (freeze_s) begin
                    cnt_s = cnt_r;
                end else if (cnt_r == CNT_LAST) begin
                    error_s = 1'b1;
                    qirq_s  = {NHARTS{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SWITCH: begin
                qirq_s   = {NHARTS{1'b0}};
                active_s = active_r & new_mask_r;
                fetch_s  = fetch_r & ~(active_r & ~new_mask_r);
                idx_s    = {IDX_W{1'b0}};
                state_s  = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (new_mask_r[idx_r] && !active_r[idx_r]) begin
                    active_s[idx_r] = 1'b1;
                    fetch_s[idx_r]  = 1'b1;
                end else begin
                    active_s = active_r;
                end
                if (idx_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            new_mask_r <= {NHARTS{1'b0}};
            active_r   <= RESET_MASK;
            fetch_r    <= RESET_MASK;
            qirq_r     <= {NHARTS{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            new_mask_r <= new_mask_s;
            active_r   <= active_s;
            fetch_r    <= fetch_s;
            qirq_r     <= qirq_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    assign fetch_enable_o   = fetch_r;
    assign quiesce_irq_o    = qirq_r;
    assign active_mask_o    = active_r;
    assign done_o           = done_r;
    assign error_o          = error_r;
    assign busy_o           = (state_r != ST_IDLE);
    assign mode_req_ready_o = (state_r == ST_IDLE);

endmodule

// File: tb/tb_cpu_cluster_mode_ctrl.sv
// Directed bench for cpu_cluster_mode_ctrl (NHARTS=3, TIMEOUT_CYCLES=8); inputs are
// driven and outputs sampled on the falling edge.
module tb_cpu_cluster_mode_ctrl;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            valid;
    logic [2:0]      mask;
    logic            ready;
    logic [2:0]      sleep;
    logic [2:0]      dbg;
    logic [2:0]      fetch;
    logic [2:0]      qirq;
    logic [2:0][31:0] hart_id;
    logic [2:0]      active;
    logic            busy;
    logic            done;
    logic            error;

    int errors = 0;
    int checks = 0;

    cpu_cluster_mode_ctrl #(
        .NHARTS(3),
        .HART_ID_BASE(32'h1),
        .RESET_MASK(3'b111),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .mode_req_valid_i(valid),
        .mode_req_mask_i(mask),
        .mode_req_ready_o(ready),
        .sleep_i(sleep),
        .ext_debug_req_i(dbg),
        .fetch_enable_o(fetch),
        .quiesce_irq_o(qirq),
        .hart_id_o(hart_id),
        .active_mask_o(active),
        .busy_o(busy),
        .done_o(done),
        .error_o(error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] exp_mask);
        chk({tag, "_active"}, {29'd0, active}, {29'd0, exp_mask});
        chk({tag, "_fetch"},  {29'd0, fetch},  {29'd0, exp_mask});
        chk({tag, "_qirq"},   {29'd0, qirq},   32'd0);
        chk({tag, "_busy"},   {31'd0, busy},   32'd0);
        chk({tag, "_ready"},  {31'd0, ready},  32'd1);
    endtask

    initial begin
        rst_i = 1'b1; valid = 1'b0; mask = 3'b000; sleep = 3'b000; dbg = 3'b000;
        step(); step();
        rst_i = 1'b0;
        // Reset state
        chk("hid0", hart_id[0], 32'd1);
        chk("hid1", hart_id[1], 32'd2);
        chk("hid2", hart_id[2], 32'd3);
        chk_idle("rst", 3'b111);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err",  {31'd0, error}, 32'd0);

        // Shrink 111 -> 001, sleep arrives 4 cycles after quiesce entry (T+5 = Q)
        valid = 1'b1; mask = 3'b001;                 // cycle T
        step(); valid = 1'b0;                        // T+1
        chk("a_ready", {31'd0, ready}, 32'd0);
        chk("a_busy",  {31'd0, busy},  32'd1);
        chk("a_qirq1", {29'd0, qirq},  32'd7);
        step(); step(); step();                      // T+4
        chk("a_qirq4", {29'd0, qirq},  32'd7);
        step(); sleep = 3'b111;                      // T+5 = Q
        step();                                      // Q+1 switch
        chk("a_fe_q1", {29'd0, fetch}, 32'd7);
        step();                                      // Q+2
        chk("a_fe_q2", {29'd0, fetch}, 32'd1);
        chk("a_qirq_q2", {29'd0, qirq}, 32'd0);
        step();                                      // Q+3
        chk("a_done_q3", {31'd0, done}, 32'd0);
        step();                                      // Q+4
        chk("a_done_q4", {31'd0, done}, 32'd0);
        chk("a_busy_q4", {31'd0, busy}, 32'd1);
        step();                                      // Q+5
        chk("a_done_q5", {31'd0, done}, 32'd1);
        chk_idle("a_end", 3'b001);
        sleep = 3'b001;
        step();
        chk("a_done_off", {31'd0, done}, 32'd0);

        // Grow 001 -> 111 with hart 0 already asleep: Q = T+1
        valid = 1'b1; mask = 3'b111;                 // T
        step(); valid = 1'b0;                        // T+1 = Q
        chk("b_qirq", {29'd0, qirq}, 32'd1);
        step(); step();                              // Q+2
        chk("b_fe_q2", {29'd0, fetch}, 32'd1);
        step();                                      // Q+3
        chk("b_fe_q3", {29'd0, fetch}, 32'd1);
        step();                                      // Q+4
        chk("b_fe_q4", {29'd0, fetch}, 32'd3);
        chk("b_done_q4", {31'd0, done}, 32'd0);
        step();                                      // Q+5
        chk("b_fe_q5", {29'd0, fetch}, 32'd7);
        chk("b_done_q5", {31'd0, done}, 32'd1);
        chk_idle("b_end", 3'b111);
        step();

        // Timeout: hart 2 never sleeps, error at T+9
        sleep = 3'b011;
        valid = 1'b1; mask = 3'b011;                 // T
        step(); valid = 1'b0;                        // T+1
        chk("c_qirq", {29'd0, qirq}, 32'd7);
        repeat (7) step();                           // T+8
        chk("c_err_t8", {31'd0, error}, 32'd0);
        chk("c_busy_t8", {31'd0, busy}, 32'd1);
        step();                                      // T+9
        chk("c_err_t9", {31'd0, error}, 32'd1);
        chk_idle("c_end", 3'b111);
        step();
        chk("c_err_off", {31'd0, error}, 32'd0);

        // Timeout with debug freeze on hart 2 for 5 cycles, error at T+14
        valid = 1'b1; mask = 3'b011;                 // T
        step(); valid = 1'b0; dbg = 3'b100;          // T+1
        repeat (4) step();                           // T+5
        step(); dbg = 3'b000;                        // T+6
        repeat (7) step();                           // T+13
        chk("d_err_t13", {31'd0, error}, 32'd0);
        chk("d_qirq_t13", {29'd0, qirq}, 32'd7);
        step();                                      // T+14
        chk("d_err_t14", {31'd0, error}, 32'd1);
        chk_idle("d_end", 3'b111);
        step();

        // Reject of an empty mask
        valid = 1'b1; mask = 3'b000;
        step(); valid = 1'b0;                        // T+1
        chk("e_err", {31'd0, error}, 32'd1);
        chk("e_done", {31'd0, done}, 32'd0);
        chk_idle("e_end", 3'b111);
        step();
        chk("e_err_off", {31'd0, error}, 32'd0);

        // Fast path: mask equals current
        valid = 1'b1; mask = 3'b111;
        step(); valid = 1'b0;                        // T+1
        chk("f_done", {31'd0, done}, 32'd1);
        chk("f_err", {31'd0, error}, 32'd0);
        chk_idle("f_end", 3'b111);
        step();
        chk("f_done_off", {31'd0, done}, 32'd0);
        chk("f_qirq_off", {29'd0, qirq}, 32'd0);

        // Reset during RELEASE
        sleep = 3'b111;
        valid = 1'b1; mask = 3'b001;                 // T
        step(); valid = 1'b0;                        // T+1 = Q
        step(); step();                              // T+3 release idx0
        chk("g_fe_rel", {29'd0, fetch}, 32'd1);
        chk("g_busy_rel", {31'd0, busy}, 32'd1);
        rst_i = 1'b1;
        step(); rst_i = 1'b0;                        // T+4
        chk_idle("g_rst", 3'b111);
        chk("g_done", {31'd0, done}, 32'd0);
        chk("g_err", {31'd0, error}, 32'd0);
        step();
        chk("g_done2", {31'd0, done}, 32'd0);
        step();
        chk("g_done3", {31'd0, done}, 32'd0);
        chk_idle("g_end", 3'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
